// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding constants, field bundle and format classification.
// Used by both the instruction encoder and the immediate decode path.
package riscv_enc_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;

    typedef enum logic [1:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B
    } fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_fields_t;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_R:          f = FMT_R;
            OP_S:          f = FMT_S;
            OP_B:          f = FMT_B;
            OP_I, OP_LOAD: f = FMT_I;
            default:       f = FMT_I;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the encoder.
interface instr_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output in_ready,
        output out_valid, out_instr, out_err,
        input  out_ready
    );

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  in_ready,
        input  out_valid, out_instr, out_err,
        output out_ready
    );

endinterface

// File: rtl/imm_field_pack.sv
// Combinational format mux: packs S1 fields into an RV32I word and flags
// immediates that are out of range or (for branches) misaligned.
module imm_field_pack
    import riscv_enc_pkg::*;
(
    input  enc_fields_t fields_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic signed [31:0] simm;
    fmt_e               fmt;

    assign simm = $signed(fields_i.imm);
    assign fmt  = fmt_of(fields_i.opcode);

    always_comb begin
        instr_o = '0;
        err_o   = 1'b0;
        case (fmt)
            FMT_R: begin
                instr_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                           fields_i.funct3, fields_i.rd, fields_i.opcode};
            end
            FMT_S: begin
                instr_o = {fields_i.imm[11:5], fields_i.rs2, fields_i.rs1,
                           fields_i.funct3, fields_i.imm[4:0], fields_i.opcode};
                err_o   = (simm < IMM_IS_MIN) || (simm > IMM_IS_MAX);
            end
            FMT_B: begin
                instr_o = {fields_i.imm[12], fields_i.imm[10:5], fields_i.rs2, fields_i.rs1,
                           fields_i.funct3, fields_i.imm[4:1], fields_i.imm[11], fields_i.opcode};
                // Odd values above IMM_B_MAX fall out via the alignment term too.
                err_o   = (simm < IMM_B_MIN) || (simm > IMM_B_MAX) || fields_i.imm[0];
            end
            default: begin
                instr_o = {fields_i.imm[11:0], fields_i.rs1, fields_i.funct3,
                           fields_i.rd, fields_i.opcode};
                err_o   = (simm < IMM_IS_MIN) || (simm > IMM_IS_MAX);
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder with valid/ready streams on both sides
// and saturating counters of delivered words and delivered error words.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    instr_encoder_if.slave   bus,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    enc_fields_t      s1_q;
    enc_fields_t      s1_d;
    logic             s1_valid_q;

    logic             out_valid_q;
    logic [31:0]      out_instr_q;
    logic             out_err_q;

    logic [31:0]      pack_instr;
    logic             pack_err;

    logic             s2_adv;
    logic             in_ready;
    logic             out_fire;

    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    assign s2_adv   = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign out_fire = out_valid_q && bus.out_ready;

    assign s1_d = '{opcode: bus.in_opcode, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2,
                    funct3: bus.in_funct3, funct7: bus.in_funct7, imm: bus.in_imm};

    imm_field_pack u_pack (
        .fields_i (s1_q),
        .instr_o  (pack_instr),
        .err_o    (pack_err)
    );

    always_comb begin
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (out_fire) begin
            if (enc_count_q != '1) begin
                enc_count_d = enc_count_q + CNT_W'(1);
            end
            if (out_err_q && (err_count_q != '1)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            // S2 reloads only when S1 holds a word; a bubble just drops out_valid.
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_instr_q <= pack_instr;
                    out_err_q   <= pack_err;
                end
            end
            if (in_ready) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= s1_d;
                end
            end
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_err   = out_err_q;
    assign enc_count     = enc_count_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed bundles, a field-level
// encoding model with an in-order scoreboard, and a CNT_W=2 saturation instance.
module tb_instr_encoder;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fields_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] enc_count, err_count;
    logic [1:0]  enc_count2, err_count2;

    always #5 clk = ~clk;

    instr_encoder_if bus ();
    instr_encoder_if bus2 ();

    instr_encoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    instr_encoder #(.CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus2),
        .enc_count (enc_count2),
        .err_count (err_count2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic fields_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] imm);
        fields_t f;
        f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.f3 = f3; f.f7 = f7; f.imm = imm;
        return f;
    endfunction

    // Returns {err, word} computed with shifts/masks from the RV32I field layout.
    function automatic logic [32:0] model_enc(input fields_t f);
        logic [31:0] w;
        logic [31:0] regs;
        logic        e;
        int          s;
        s    = f.imm;
        regs = (32'(f.rs2) << 20) | (32'(f.rs1) << 15) | (32'(f.f3) << 12) | 32'(f.op);
        case (f.op)
            7'b0110011: begin
                w = regs | (32'(f.f7) << 25) | (32'(f.rd) << 7);
                e = 1'b0;
            end
            7'b0100011: begin
                w = regs | (((f.imm >> 5) & 32'h7F) << 25) | ((f.imm & 32'h1F) << 7);
                e = (s < -2048) || (s > 2047);
            end
            7'b1100011: begin
                w = regs | (((f.imm >> 12) & 32'd1) << 31) | (((f.imm >> 5) & 32'h3F) << 25)
                         | (((f.imm >> 1) & 32'hF) << 8) | (((f.imm >> 11) & 32'd1) << 7);
                e = (s < -4096) || (s > 4095) || ((s % 2) != 0);
            end
            default: begin
                w = (regs & ~(32'h1F << 20)) | ((f.imm & 32'hFFF) << 20) | (32'(f.rd) << 7);
                e = (s < -2048) || (s > 2047);
            end
        endcase
        return {e, w};
    endfunction

    // Scoreboard state, updated on negedges for the handshakes of the coming posedge.
    logic [32:0] exp_q[$];
    logic [32:0] delivered[$];
    int          fire_cyc[$];
    int          cyc       = 0;
    int          acc_cnt   = 0;
    int          model_enc_cnt = 0;
    int          model_err_cnt = 0;
    logic        hold_prev = 1'b0;
    logic [32:0] held      = '0;

    always @(negedge clk) begin
        fields_t     f;
        logic [32:0] e;
        cyc++;
        check("enc_count", 64'(enc_count), 64'(model_enc_cnt));
        check("err_count", 64'(err_count), 64'(model_err_cnt));
        if (hold_prev && !rst) begin
            check("out_hold", 64'({bus.out_err, bus.out_instr}), 64'(held));
        end
        if (rst) begin
            exp_q.delete();
            model_enc_cnt = 0;
            model_err_cnt = 0;
            hold_prev     = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stale_word", 64'(bus.out_instr), 64'hDEAD_0000_0000);
                    e = {bus.out_err, bus.out_instr};
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", 64'({bus.out_err, bus.out_instr}), 64'(e));
                end
                delivered.push_back({bus.out_err, bus.out_instr});
                fire_cyc.push_back(cyc);
                if (model_enc_cnt != 65535) model_enc_cnt++;
                if (e[32] && model_err_cnt != 65535) model_err_cnt++;
            end
            if (bus.in_valid && bus.in_ready) begin
                f = mk(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                       bus.in_funct3, bus.in_funct7, bus.in_imm);
                exp_q.push_back(model_enc(f));
                acc_cnt++;
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            held      = {bus.out_err, bus.out_instr};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input fields_t f);
        bus.in_opcode = f.op;  bus.in_rd = f.rd;   bus.in_rs1 = f.rs1; bus.in_rs2 = f.rs2;
        bus.in_funct3 = f.f3;  bus.in_funct7 = f.f7; bus.in_imm = f.imm;
    endtask

    // Holds the bundle valid until accepted; returns just after the accepting edge.
    task automatic send(input fields_t f);
        drive(f);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                bus.in_valid = 1'b0;
                return;
            end
            step();
        end
        checks++;
        failures++;
        $display("FAIL send_timeout actual=in_ready_low required=accept_within_20");
        bus.in_valid = 1'b0;
    endtask

    task automatic drive2(input fields_t f);
        bus2.in_opcode = f.op;  bus2.in_rd = f.rd;   bus2.in_rs1 = f.rs1; bus2.in_rs2 = f.rs2;
        bus2.in_funct3 = f.f3;  bus2.in_funct7 = f.f7; bus2.in_imm = f.imm;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fields_t addi, sw, beq;
        fields_t bp[4];
        int      base, n0;

        addi = mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
        sw   = mk(7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'hFFFF_FFFC);
        beq  = mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd8);

        rst = 1'b1;
        drive(mk(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        drive2(mk(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_instr", 64'(bus.out_instr), 64'd0);
        check("rst_out_err",   64'(bus.out_err),   64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_enc_count", 64'(enc_count),     64'd0);
        check("rst_err_count", 64'(err_count),     64'd0);
        step();

        check("model_addi", 64'(model_enc(addi)), 64'h0_0050_0093);
        check("model_sw",   64'(model_enc(sw)),   64'h0_FE21_AE23);
        check("model_beq",  64'(model_enc(beq)),  64'h0_0020_8463);

        // Accept edge, then one edge into S2: visible two cycles after the offer.
        send(addi);
        @(negedge clk);
        check("lat_s1_only", 64'(bus.out_valid), 64'd0);
        step();
        @(negedge clk);
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("addi_word", 64'(bus.out_instr), 64'h0050_0093);
        check("addi_err",  64'(bus.out_err),   64'd0);
        step();
        @(negedge clk);
        check("addi_enc_count", 64'(enc_count), 64'd1);
        step();

        send(sw);
        send(beq);
        repeat (3) step();
        check("sw_word",  64'(delivered[1]), 64'h0_FE21_AE23);
        check("beq_word", 64'(delivered[2]), 64'h0_0020_8463);

        send(mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd7));
        send(mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096));
        send(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048));
        repeat (3) step();
        check("err_b_misaligned", 64'(delivered[3][32]), 64'd1);
        check("err_b_range",      64'(delivered[4][32]), 64'd1);
        check("err_i_range",      64'(delivered[5][32]), 64'd1);
        check("err_count_3",      64'(err_count),        64'd3);

        send(mk(7'b0010011, 5'd4, 5'd5, 5'd0, 3'b000, 7'd0, 32'hFFFF_F800));
        send(mk(7'b0100011, 5'd0, 5'd6, 5'd7, 3'b010, 7'd0, 32'd2047));
        send(mk(7'b1100011, 5'd0, 5'd8, 5'd9, 3'b001, 7'd0, 32'hFFFF_F000));
        send(mk(7'b1100011, 5'd0, 5'd8, 5'd9, 3'b001, 7'd0, 32'd4094));
        send(mk(7'b0110011, 5'd10, 5'd11, 5'd12, 3'b000, 7'b0100000, 32'hDEAD_BEEF));
        send(mk(7'b0000011, 5'd2, 5'd3, 5'd0, 3'b010, 7'd0, 32'hFFFF_F7FF));
        repeat (3) step();
        check("bound_i_min_ok", 64'(delivered[6][32]), 64'd0);
        check("bound_b_max_ok", 64'(delivered[9][32]), 64'd0);
        check("r_type_word",    64'(delivered[10]),    64'h0_40C5_8533);
        check("load_below_min", 64'(delivered[11][32]), 64'd1);
        check("err_count_4",    64'(err_count),         64'd4);

        for (int i = 0; i < 4; i++) begin
            bp[i] = mk(7'b0010011, 5'(i + 1), 5'(i + 2), 5'd0, 3'b000, 7'd0, 32'(100 * i));
        end
        bus.out_ready = 1'b0;
        base = acc_cnt;
        n0   = delivered.size();
        send(bp[0]);
        send(bp[1]);
        drive(bp[2]);
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("bp_accepted_2",   64'(acc_cnt - base), 64'd2);
            step();
        end
        bus.out_ready = 1'b1;
        send(bp[2]);
        send(bp[3]);
        repeat (4) step();
        check("bp_delivered_4", 64'(delivered.size() - n0), 64'd4);
        for (int i = 1; i < 4; i++) begin
            check("bp_one_per_cycle",
                  64'(fire_cyc[fire_cyc.size() - 4 + i] - fire_cyc[fire_cyc.size() - 5 + i]), 64'd1);
        end

        bus.out_ready = 1'b0;
        send(bp[0]);
        send(bp[1]);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("mid_rst_enc_count", 64'(enc_count),     64'd0);
        check("mid_rst_err_count", 64'(err_count),     64'd0);
        step();
        n0 = delivered.size();
        bus.out_ready = 1'b1;
        repeat (5) step();
        check("mid_rst_no_stale", 64'(delivered.size() - n0), 64'd0);
        send(addi);
        repeat (3) step();
        check("post_rst_word",  64'(delivered[delivered.size() - 1]), 64'h0_0050_0093);
        check("post_rst_count", 64'(enc_count), 64'd1);

        drive2(mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd7));
        bus2.in_valid = 1'b1;
        step();
        drive2(addi);
        step();
        bus2.in_valid = 1'b0;
        repeat (4) step();
        check("sat_enc_2", 64'(enc_count2), 64'd2);
        check("sat_err_1", 64'(err_count2), 64'd1);
        drive2(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4000));
        bus2.in_valid = 1'b1;
        repeat (3) step();
        bus2.in_valid = 1'b0;
        repeat (4) step();
        check("sat_enc_held", 64'(enc_count2), 64'd3);
        check("sat_err_held", 64'(err_count2), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
